// File: rtl/uart_xcvr_param_pkg.sv
// Shared UART types: TX/RX state encodings, parity selectors, bit-timer width helper.
// Parity states exist only when UART_PARITY_EN is defined.
// No logic, no latency, no backpressure.
package uart_pkg;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// SoC-side TX/RX word streams plus the serial pins of the UART transceiver.
// master = SoC/bench side, slave = transceiver side.
// Valid/ready on both word streams; rx_overrun flags words dropped while full.
interface uart_xcvr_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 ser_tx;
  logic                 ser_rx;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output tx_valid, tx_data, ser_rx, rx_ready,
    input  tx_ready, tx_done, ser_tx, rx_valid, rx_data,
           rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_valid, tx_data, ser_rx, rx_ready,
    output tx_ready, tx_done, ser_tx, rx_valid, rx_data,
           rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear; tick at half or full period.
// Tick is combinational from the count; i_clr makes the next cycle count 0.
// No backpressure.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_half,
  output logic o_tick
);
  localparam int W = cnt_width(CLKS_PER_BIT);

  logic [W-1:0] r_cnt;
  logic         w_full;
  logic         w_half;

  assign w_full = (r_cnt == W'(CLKS_PER_BIT - 1));
  assign w_half = (r_cnt == W'(CLKS_PER_BIT / 2 - 1));
  assign o_tick = i_half ? w_half : w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_full) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART, LSB first, optional parity bit under UART_PARITY_EN.
// TX: start bit one cycle after accept; RX: word valid the cycle after the stop-bit mid sample.
// tx_ready low for the whole frame; a full RX holding register drops new words and pulses rx_overrun.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input logic               clk,
  input logic               rst_n,
  uart_xcvr_param_if.slave  bus
);
  // ---------------- transmitter ----------------
  tx_state_e            r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [3:0]           r_tx_bit;
  logic                 r_ser_tx;
  logic                 r_tx_ready;
  logic                 w_tx_tick;
  logic                 w_tx_clr;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_clr    = (r_tx_state == TX_IDLE);
  assign bus.ser_tx   = r_ser_tx;
  assign bus.tx_ready = r_tx_ready;
  assign bus.tx_done  = (r_tx_state == TX_STOP) && (r_tx_bit == 4'(STOP_BITS - 1)) && w_tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk(clk), .rst_n(rst_n), .i_clr(w_tx_clr), .i_half(1'b0), .o_tick(w_tx_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_ser_tx   <= 1'b1;
      r_tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: if (bus.tx_valid) begin
          r_tx_shift <= bus.tx_data;
`ifdef UART_PARITY_EN
          r_tx_par   <= (^bus.tx_data) ^ (PARITY_ODD != 0);
`endif
          r_ser_tx   <= 1'b0;
          r_tx_ready <= 1'b0;
          r_tx_bit   <= '0;
          r_tx_state <= TX_START;
        end
        TX_START: if (w_tx_tick) begin
          r_ser_tx   <= r_tx_shift[0];
          r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tx_tick) begin
          if (r_tx_bit == 4'(DATA_BITS - 1)) begin
            r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
            r_ser_tx   <= r_tx_par;
            r_tx_state <= TX_PARITY;
`else
            r_ser_tx   <= 1'b1;
            r_tx_state <= TX_STOP;
`endif
          end else begin
            r_ser_tx   <= r_tx_shift[1];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (w_tx_tick) begin
          r_ser_tx   <= 1'b1;
          r_tx_state <= TX_STOP;
        end
`endif
        TX_STOP: if (w_tx_tick) begin
          if (r_tx_bit == 4'(STOP_BITS - 1)) begin
            r_tx_ready <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_bit   <= r_tx_bit + 4'd1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 r_sync1, r_sync2;
  rx_state_e            r_rx_state;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_overrun;
  logic                 w_rx, w_rx_tick, w_rx_clr, w_rx_half, w_done, w_load;
`ifdef UART_PARITY_EN
  logic                 r_rx_par, r_parity_err;
`endif

  assign w_rx      = r_sync2;
  assign w_rx_half = (r_rx_state == RX_START);
  // Restart the timer at the start-bit midpoint so later full ticks land mid-bit.
  assign w_rx_clr  = (r_rx_state == RX_IDLE) || (w_rx_half && w_rx_tick);
  assign w_done    = (r_rx_state == RX_STOP) && w_rx_tick;
  assign w_load    = w_done && (!r_rx_valid || bus.rx_ready);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk(clk), .rst_n(rst_n), .i_clr(w_rx_clr), .i_half(w_rx_half), .o_tick(w_rx_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.ser_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
`endif
    end else begin
      case (r_rx_state)
        RX_IDLE: if (!w_rx) r_rx_state <= RX_START;
        RX_START: if (w_rx_tick) begin
          r_rx_bit   <= '0;
          r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_rx_tick) begin
          r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            r_rx_state <= RX_PARITY;
`else
            r_rx_state <= RX_STOP;
`endif
          end else begin
            r_rx_bit <= r_rx_bit + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (w_rx_tick) begin
          r_rx_par   <= w_rx;
          r_rx_state <= RX_STOP;
        end
`endif
        RX_STOP: if (w_rx_tick) r_rx_state <= w_rx ? RX_IDLE : RX_WAIT_HIGH;
        RX_WAIT_HIGH: if (w_rx) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (w_load) begin
        r_rx_data    <= r_rx_shift;
        r_frame_err  <= !w_rx;
`ifdef UART_PARITY_EN
        r_parity_err <= (^r_rx_shift) ^ r_rx_par ^ (PARITY_ODD != 0);
`endif
        r_rx_valid   <= 1'b1;
      end else if (w_done) begin
        r_overrun <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_frame_err = r_frame_err;
  assign bus.rx_overrun   = r_overrun;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = r_parity_err;
`else
  assign bus.rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed + random bench for uart_xcvr_param against a frame-level reference model.
module tb_uart_xcvr_param;
  localparam int DB   = 8;
  localparam int CLKS = 16;
  localparam int SB   = 1;
  localparam int PO   = 0;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB  = 1 + DB + PB + SB;
  localparam int TOT = NB * CLKS;

  logic clk = 1'b0;
  logic rst_n;
  logic r_loop;
  logic r_rx_pin;
`ifdef UART_PARITY_EN
  logic r_par_flip;
`endif

  int errors = 0;
  int checks = 0;
  int r_gp   = 0;
  int ovr_cnt = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_xcvr_param_if #(.DATA_BITS(DB)) bus ();
  assign bus.ser_rx = r_loop ? bus.ser_tx : r_rx_pin;

  uart_xcvr_param #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CLKS), .STOP_BITS(SB), .PARITY_ODD(PO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Word monitor: a word is consumed whenever valid and ready coincide.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1)
        got.push_back(32'({bus.rx_parity_err, bus.rx_frame_err, bus.rx_data}));
      if (bus.rx_overrun === 1'b1) ovr_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic ref_parity(input logic [DB-1:0] d);
    return ((($countones(d) % 2) == 1) != (PO == 1));
  endfunction

  function automatic logic frame_bit(input logic [DB-1:0] d, input int i);
    logic [DB-1:0] t;
    if (i == 0) return 1'b0;
    if (i <= DB) begin
      t = d >> (i - 1);
      return t[0];
    end
    if (PB == 1 && i == DB + 1) return ref_parity(d);
    return 1'b1;
  endfunction

  function automatic logic [31:0] enc(input logic pe, input logic fe, input logic [DB-1:0] d);
    return 32'({pe, fe, d});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_rx();
    int n;
    n = got.size() - r_gp;
    check("rx_word_count", 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check("rx_word", got[r_gp + i], exp_q[i]);
    r_gp = got.size();
    exp_q.delete();
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.rx_ready = v;
    @(negedge clk);
  endtask

  // Offer one word and compare the whole serial waveform cycle by cycle.
  task automatic tx_frame(input logic [DB-1:0] d);
    int bad, done_k, done_n;
    bad = 0; done_k = 0; done_n = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = DB'($urandom);
    check("tx_ready_busy", 32'(bus.tx_ready), 32'(0));
    for (int k = 1; k <= TOT; k++) begin
      if (bus.ser_tx !== frame_bit(d, (k - 1) / CLKS)) bad++;
      if (bus.tx_done === 1'b1) begin done_n++; done_k = k; end
      @(negedge clk);
    end
    check("tx_bits_bad", 32'(bad), 32'(0));
    check("tx_done_cycle", 32'(done_k), 32'(TOT));
    check("tx_done_count", 32'(done_n), 32'(1));
    check("tx_ready_after", 32'(bus.tx_ready), 32'(1));
    check("ser_tx_idle", 32'(bus.ser_tx), 32'(1));
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input logic stop_val, input int stop_cyc);
    for (int i = 0; i < 1 + DB + PB; i++) begin
      logic b;
      b = frame_bit(d, i);
`ifdef UART_PARITY_EN
      if (i == DB + 1) b = b ^ r_par_flip;
`endif
      r_rx_pin = b;
      repeat (CLKS) @(negedge clk);
    end
    r_rx_pin = stop_val;
    repeat (stop_cyc) @(negedge clk);
    r_rx_pin = 1'b1;
    repeat (CLKS) @(negedge clk);
  endtask

  initial begin
    logic [DB-1:0] d;
    int base;
    rst_n        = 1'b0;
    r_loop       = 1'b0;
    r_rx_pin     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_ready = 1'b1;
`ifdef UART_PARITY_EN
    r_par_flip   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ser_tx", 32'(bus.ser_tx), 32'(1));
    check("rst_tx_ready", 32'(bus.tx_ready), 32'(1));
    check("rst_tx_done", 32'(bus.tx_done), 32'(0));
    check("rst_rx_valid", 32'(bus.rx_valid), 32'(0));
    check("rst_rx_data", 32'(bus.rx_data), 32'(0));
    check("rst_frame_err", 32'(bus.rx_frame_err), 32'(0));
    check("rst_parity_err", 32'(bus.rx_parity_err), 32'(0));
    check("rst_overrun", 32'(bus.rx_overrun), 32'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single TX word with the receiver input held idle.
    d = DB'('hA5);
    tx_frame(d);
    check_rx();

    // Loopback: back-to-back directed and random words.
    r_loop = 1'b1;
    repeat (2) @(negedge clk);
    d = DB'('h3C); tx_frame(d); exp_q.push_back(enc(1'b0, 1'b0, d));
    d = DB'('hC3); tx_frame(d); exp_q.push_back(enc(1'b0, 1'b0, d));
    for (int n = 0; n < 4; n++) begin
      d = DB'($urandom);
      tx_frame(d);
      exp_q.push_back(enc(1'b0, 1'b0, d));
    end
    repeat (2 * CLKS) @(negedge clk);
    check_rx();

    // Short low glitch on the idle line must be ignored.
    r_loop   = 1'b0;
    r_rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    r_rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_valid", 32'(bus.rx_valid), 32'(0));
    check_rx();
    d = DB'('h55);
    drive_frame(d, 1'b1, CLKS * SB);
    exp_q.push_back(enc(1'b0, 1'b0, d));
    check_rx();

    // Stop bit held low (break), then a clean frame.
    d = DB'('h81);
    drive_frame(d, 1'b0, 40);
    exp_q.push_back(enc(1'b0, 1'b1, d));
    d = DB'('h7E);
    drive_frame(d, 1'b1, CLKS * SB);
    exp_q.push_back(enc(1'b0, 1'b0, d));
    check_rx();

    // Overrun: second word arrives while the first is still held.
    set_ready(1'b0);
    base = ovr_cnt;
    drive_frame(DB'('h11), 1'b1, CLKS * SB);
    drive_frame(DB'('h22), 1'b1, CLKS * SB);
    check("ovr_pulses", 32'(ovr_cnt - base), 32'(1));
    check("ovr_rx_valid", 32'(bus.rx_valid), 32'(1));
    check("ovr_rx_data", 32'(bus.rx_data), 32'('h11));
    check("ovr_frame_err", 32'(bus.rx_frame_err), 32'(0));
    set_ready(1'b1);
    exp_q.push_back(enc(1'b0, 1'b0, DB'('h11)));
    repeat (2) @(negedge clk);
    check("ovr_drained", 32'(bus.rx_valid), 32'(0));
    check_rx();

`ifdef UART_PARITY_EN
    // Parity: correct parity via loopback, then a corrupted parity bit.
    r_loop = 1'b1;
    repeat (2) @(negedge clk);
    d = DB'('hA5);
    tx_frame(d);
    exp_q.push_back(enc(1'b0, 1'b0, d));
    repeat (CLKS) @(negedge clk);
    r_loop = 1'b0;
    r_par_flip = 1'b1;
    drive_frame(d, 1'b1, CLKS * SB);
    r_par_flip = 1'b0;
    exp_q.push_back(enc(1'b1, 1'b0, d));
    check_rx();
`endif

    // Reset in the middle of a data bit while a received word is held.
    set_ready(1'b0);
    r_loop = 1'b1;
    repeat (2) @(negedge clk);
    d = DB'($urandom);
    tx_frame(d);
    check("hold_rx_valid", 32'(bus.rx_valid), 32'(1));
    check("hold_rx_data", 32'(bus.rx_data), 32'(d));
    bus.tx_valid = 1'b1;
    bus.tx_data  = '0;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (59) @(negedge clk);
    check("mid_data_ser_tx", 32'(bus.ser_tx), 32'(0));
    rst_n = 1'b0;
    #1;
    check("mrst_ser_tx", 32'(bus.ser_tx), 32'(1));
    check("mrst_rx_valid", 32'(bus.rx_valid), 32'(0));
    check("mrst_tx_ready", 32'(bus.tx_ready), 32'(1));
    check("mrst_rx_data", 32'(bus.rx_data), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    repeat (3 * CLKS) @(negedge clk);
    check("post_rst_rx_valid", 32'(bus.rx_valid), 32'(0));
    check_rx();
    d = DB'($urandom);
    tx_frame(d);
    exp_q.push_back(enc(1'b0, 1'b0, d));
    repeat (2 * CLKS) @(negedge clk);
    check_rx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
